// File: rtl/csr_counter_ctrl_if.sv
// CSR request/response channel between the execute stage (master) and the
// performance-counter control unit (slave).
interface csr_counter_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_op, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/csr_counter_ctrl.sv
// Cycle/instret counters, mcountinhibit and their CSR access FSM (IDLE -> EXEC -> RESP).
// Optional CSR_CNT_SNAPSHOT_EN: a low-half read shadows the high half for torn-free 64-bit reads.
module csr_counter_ctrl #(
  parameter int CNT_W = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              retire,
  input  logic              stall,
  input  logic              flush,
  csr_counter_ctrl_if.slave bus,
  output logic [CNT_W-1:0]  cycle_o,
  output logic [CNT_W-1:0]  instret_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [11:0]       addr_r;
  logic [1:0]        op_r;
  logic [31:0]       wdata_r;
  logic [CNT_W-1:0]  cycle_r, cycle_s;
  logic [CNT_W-1:0]  instret_r, instret_s;
  logic              inh_cy_r, inh_cy_s;
  logic              inh_ir_r, inh_ir_s;
  logic              started_r;
  logic              rsp_valid_r, rsp_err_r;
  logic [31:0]       rsp_rdata_r;

  logic              hit_s, ro_s, hi_s, sel_cy_s, sel_ir_s, sel_inh_s;
  logic              modify_s, err_s, wr_s;
  logic [31:0]       old_s, new_s, rdata_s;

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign cycle_o       = cycle_r;
  assign instret_o     = instret_r;

  // FSM state register and request latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      addr_r  <= 12'd0;
      op_r    <= 2'd0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && bus.req_valid) begin
        addr_r  <= bus.req_addr;
        op_r    <= bus.req_op;
        wdata_r <= bus.req_wdata;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.req_valid) state_s = EXEC; else state_s = IDLE;
      EXEC:    state_s = RESP;
      RESP:    if (bus.rsp_ready) state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // Address decode of the latched request
  always_comb begin
    hit_s     = 1'b1;
    ro_s      = 1'b0;
    hi_s      = 1'b0;
    sel_cy_s  = 1'b0;
    sel_ir_s  = 1'b0;
    sel_inh_s = 1'b0;
    case (addr_r)
      12'hB00: sel_cy_s = 1'b1;
      12'hB80: begin sel_cy_s = 1'b1; hi_s = 1'b1; end
      12'hB02: sel_ir_s = 1'b1;
      12'hB82: begin sel_ir_s = 1'b1; hi_s = 1'b1; end
      12'hC00: begin sel_cy_s = 1'b1; ro_s = 1'b1; end
      12'hC80: begin sel_cy_s = 1'b1; ro_s = 1'b1; hi_s = 1'b1; end
      12'hC02: begin sel_ir_s = 1'b1; ro_s = 1'b1; end
      12'hC82: begin sel_ir_s = 1'b1; ro_s = 1'b1; hi_s = 1'b1; end
      12'h320: sel_inh_s = 1'b1;
      default: hit_s = 1'b0;
    endcase
  end

  // Old value, legality and read-modify-write result
  always_comb begin
    if (sel_inh_s)     old_s = {29'd0, inh_ir_r, 1'b0, inh_cy_r};
    else if (sel_cy_s) old_s = hi_s ? cycle_r[63:32] : cycle_r[31:0];
    else if (sel_ir_s) old_s = hi_s ? instret_r[63:32] : instret_r[31:0];
    else               old_s = 32'd0;
    // set/clear with a zero operand is a pure read, so it is legal on RO counters
    modify_s = (op_r == 2'b01) || (op_r[1] && (wdata_r != 32'd0));
    err_s    = !hit_s || (ro_s && modify_s);
    case (op_r)
      2'b01:   new_s = wdata_r;
      2'b10:   new_s = old_s | wdata_r;
      2'b11:   new_s = old_s & ~wdata_r;
      default: new_s = old_s;
    endcase
    wr_s = (state_r == EXEC) && !err_s && modify_s;
  end

  // Next counter/inhibit values; a CSR write beats that cycle's increment
  always_comb begin
    if (wr_s && sel_cy_s && hi_s)      cycle_s = {new_s, cycle_r[31:0]};
    else if (wr_s && sel_cy_s)         cycle_s = {cycle_r[63:32], new_s};
    else if (started_r && !inh_cy_r)   cycle_s = cycle_r + 64'd1;
    else                               cycle_s = cycle_r;

    if (wr_s && sel_ir_s && hi_s)      instret_s = {new_s, instret_r[31:0]};
    else if (wr_s && sel_ir_s)         instret_s = {instret_r[63:32], new_s};
    else if (retire && !stall && !flush && !inh_ir_r) instret_s = instret_r + 64'd1;
    else                               instret_s = instret_r;

    if (wr_s && sel_inh_s) begin
      inh_cy_s = new_s[0];
      inh_ir_s = new_s[2];
    end else begin
      inh_cy_s = inh_cy_r;
      inh_ir_s = inh_ir_r;
    end
  end

  // Counter and inhibit registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
      inh_cy_r  <= 1'b0;
      inh_ir_r  <= 1'b0;
      started_r <= 1'b0;
    end else begin
      cycle_r   <= cycle_s;
      instret_r <= instret_s;
      inh_cy_r  <= inh_cy_s;
      inh_ir_r  <= inh_ir_s;
      started_r <= 1'b1;
    end
  end

`ifdef CSR_CNT_SNAPSHOT_EN
  logic [31:0] snap_cy_r, snap_ir_r;
  logic        snap_cy_vld_r, snap_ir_vld_r;

  // High-half reads return the shadow while it is valid
  always_comb begin
    if (sel_cy_s && hi_s && !modify_s && snap_cy_vld_r)      rdata_s = snap_cy_r;
    else if (sel_ir_s && hi_s && !modify_s && snap_ir_vld_r) rdata_s = snap_ir_r;
    else                                                     rdata_s = old_s;
  end

  // Shadow capture on a low-half read; any other access to that counter invalidates it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_cy_r     <= 32'd0;
      snap_ir_r     <= 32'd0;
      snap_cy_vld_r <= 1'b0;
      snap_ir_vld_r <= 1'b0;
    end else if (state_r == EXEC && !err_s) begin
      if (sel_cy_s && !hi_s && !modify_s) begin
        snap_cy_r     <= cycle_r[63:32];
        snap_cy_vld_r <= 1'b1;
      end else if (sel_cy_s) begin
        snap_cy_vld_r <= 1'b0;
      end
      if (sel_ir_s && !hi_s && !modify_s) begin
        snap_ir_r     <= instret_r[63:32];
        snap_ir_vld_r <= 1'b1;
      end else if (sel_ir_s) begin
        snap_ir_vld_r <= 1'b0;
      end
    end
  end
`else
  assign rdata_s = old_s;
`endif

  // Response registers, held stable through RESP
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      case (state_r)
        EXEC: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= err_s;
          rsp_rdata_r <= err_s ? 32'd0 : rdata_s;
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_r <= 1'b0;
          else               rsp_valid_r <= 1'b1;
        end
        default: rsp_valid_r <= rsp_valid_r;
      endcase
    end
  end

endmodule

// File: doc/csr_counter_ctrl.md
# csr_counter_ctrl

Control and access unit for the machine/user performance counters (cycle and instret) in the CSR file. It owns both 64-bit counters and the `mcountinhibit` bits, and gates counting from pipeline retire/stall/flush status. It serves 32-bit CSR read/write/set/clear requests from the execute stage over a valid/ready request channel and a valid/ready response channel. It drives the live counter values to other consumers (trap logic, debug).

## Interface
- `CNT_W`, default 64: counter width; must be 64.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `retire` in 1: one instruction retires this cycle.
- `stall` in 1: pipeline stalled; suppresses `retire`.
- `flush` in 1: pipeline flushed; suppresses `retire`.
- `req_valid` in 1: CSR request valid.
- `req_ready` out 1: request accepted when high with `req_valid`.
- `req_addr` in 12: CSR address.
- `req_op` in 2: 00 read, 01 write, 10 set bits, 11 clear bits.
- `req_wdata` in 32: write/set/clear operand.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_rdata` out 32: old CSR value (pre-modification).
- `rsp_err` out 1: illegal access.
- `cycle_o` out 64: live cycle counter.
- `instret_o` out 64: live instret counter.

## Operation
- Address map:
  - 0xB00/0xB80: mcycle/mcycleh, RW.
  - 0xB02/0xB82: minstret/minstreth, RW.
  - 0xC00/0xC80: cycle/cycleh, RO.
  - 0xC02/0xC82: instret/instreth, RO.
  - 0x320: mcountinhibit, RW, bit0 = CY, bit2 = IR, other bits read 0.
- "Modifying" means op 01, or op 10/11 with `req_wdata != 0`.
- Illegal cases: any other address, or a modifying op to an RO address.
  - Response: `rsp_err=1`, `rsp_rdata=0`, no state change.
- New value:
  - write: `wdata`
  - set: `old | wdata`
  - clear: `old & ~wdata`
- Low-half write replaces bits [31:0]; high-half write replaces bits [63:32].
- FSM, states IDLE, EXEC, RESP:
  - IDLE: `req_ready=1`. Accept on `req_valid` and latch addr/op/wdata, then go to EXEC.
  - EXEC: read old value, apply the write, load `rsp_rdata`/`rsp_err`, then go to RESP.
  - RESP: `rsp_valid=1`, outputs held stable. On `rsp_ready`, go to IDLE.
- Cycle counter:
  - +1 every cycle unless inhibit CY = 1.
  - Not incremented in the first cycle after reset release.
- Instret counter: +1 when `retire & ~stall & ~flush & ~IR`.
- A CSR write in EXEC to a counter takes priority over that cycle's increment. The increment is dropped and the counter holds the written value.
- Counters wrap from 2^64-1 to 0 silently. Carry from the low half propagates to the high half in the same cycle.

## Timing
- Reset values:
  - counters 0, inhibit 0, state IDLE.
  - `req_ready=1` (combinational from state, valid during reset).
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- Latency: request accepted at edge N; written state visible at edge N+1; `rsp_valid` high after edge N+1.
- No back-to-back acceptance. The next request is accepted in IDLE at the earliest one cycle after the `rsp_ready` handshake.
- Read value = counter value at the start of the EXEC cycle.
- Inhibit write takes effect from the cycle after EXEC. The EXEC cycle itself uses the old inhibit.
- `RST_N` low mid-transaction:
  - FSM returns to IDLE and the pending request is dropped.
  - `rsp_valid` drops immediately (asynchronous).

## Configuration
- `CSR_CNT_SNAPSHOT_EN` defined:
  - A successful read of a low half (0xB00/0xC00/0xB02/0xC02) latches that counter's current high half into a per-counter shadow and sets a shadow-valid bit.
  - The next read of the matching high half returns the shadow and clears the valid bit.
  - Any write to that counter clears its valid bit.
  - Result: torn-free two-read 64-bit access.
- Undefined: high-half reads always return the live value; no shadow registers.

## Test plan
- Reset, release, idle 10 cycles, inhibit 0 -> `cycle_o=9`, `instret_o=0`, `req_ready=1`, `rsp_valid=0`.
- Write 0x320 wdata 0x5 -> `cycle_o` and `instret_o` frozen.
  - Read 0x320 -> `rsp_rdata=0x5`.
  - Clear 0x5 -> counting resumes.
- `retire` high 4 cycles with one of them also `stall`, one also `flush` -> `instret_o` +2.
- mcycle write 0xFFFFFFFF, mcycleh write 0 -> next cycle `cycle_o=0x1_0000_0000`.
  - With the macro: read 0xC00, wait 5 cycles, read 0xC80 -> returns the high half captured at the low read.
- Write 0xC00 -> `rsp_err=1`, `rsp_rdata=0`, counter unchanged.
  - Set 0xC00 with wdata 0 -> `rsp_err=0`.
  - Read 0x7FF -> `rsp_err=1`.
- Hold `rsp_ready=0` 6 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready=0`.
  - Assert `RST_N` low during RESP -> `rsp_valid=0` immediately, IDLE after release.
